// File: rtl/led_band_pkg.sv
// led_band_pkg: shared state encoding and default FC command lengths
package led_band_pkg;
  typedef enum logic [2:0] {IDLE, LAT_EN, SHIFT, LAT_WR, DONE} state_t;
  localparam int FCWRTEN_SCLKS = 15;
  localparam int WRTFC_SCLKS = 5;
  localparam int FC_WIDTH = 48;
endpackage

// File: rtl/led_band_fc_sequencer_if.sv
// led_band_fc_sequencer_if: start/busy/done handshake plus SCLK/LAT driver lines
interface led_band_fc_sequencer_if;
  logic start;
  logic SCLK;
  logic LAT;
  logic busy;
  logic done;
  modport master (output start, input SCLK, LAT, busy, done);
  modport slave (input start, output SCLK, LAT, busy, done);
endinterface

// File: rtl/sclk_tick_gen.sv
// sclk_tick_gen: one-clk tick every SCLK_HALF clks, restartable by clear
module sclk_tick_gen #(
  parameter int SCLK_HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(SCLK_HALF);
  logic [W-1:0] r_cnt;
  assign tick = r_cnt == W'(SCLK_HALF - 1);
  always_ff @(posedge clk)
    if (!rst_n || clear || tick) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/led_band_fc_sequencer.sv
// led_band_fc_sequencer: FCWRTEN latch, FC shift and WRTFC latch SCLK/LAT sequence
module led_band_fc_sequencer
  import led_band_pkg::*;
#(
  parameter int SCLK_HALF = 2,
  parameter int FCWRTEN_PULSES = FCWRTEN_SCLKS,
  parameter int FC_BITS = FC_WIDTH,
  parameter int WRTFC_PULSES = WRTFC_SCLKS,
  parameter bit START_ON_RESET = 1'b1
) (
  input logic clk,
  input logic rst_n,
  led_band_fc_sequencer_if.slave bus
);
  state_t r_state, w_state_nxt;
  logic r_pend, r_sclk, r_lat, r_busy, r_done;
  logic [5:0] r_pcnt, w_pcnt_nxt, w_n;
  logic w_tick, w_accept, w_phase, w_end;
  logic w_sclk_nxt, w_lat_nxt, w_busy_nxt, w_done_nxt;

  sclk_tick_gen #(.SCLK_HALF(SCLK_HALF)) u_tick (
    .clk(clk), .rst_n(rst_n), .clear(w_accept), .tick(w_tick)
  );

  assign w_accept = r_state == IDLE && (bus.start || r_pend);
  assign w_phase = r_state == LAT_EN || r_state == SHIFT || r_state == LAT_WR;
  assign w_n = r_state == LAT_EN ? 6'(FCWRTEN_PULSES) : r_state == SHIFT ? 6'(FC_BITS) : 6'(WRTFC_PULSES);
  // a phase ends on the tick after its last falling edge
  assign w_end = w_phase && w_tick && !r_sclk && r_pcnt == w_n;

  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= IDLE;
      r_pend <= START_ON_RESET;
      r_sclk <= 1'b0;
      r_lat <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pcnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend <= r_pend && !w_accept;
      r_sclk <= w_sclk_nxt;
      r_lat <= w_lat_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_pcnt <= w_pcnt_nxt;
    end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_accept ? LAT_EN : IDLE;
      LAT_EN:  w_state_nxt = w_end ? SHIFT : LAT_EN;
      SHIFT:   w_state_nxt = w_end ? LAT_WR : SHIFT;
      LAT_WR:  w_state_nxt = w_end ? DONE : LAT_WR;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_sclk_nxt = w_phase && (r_sclk ^ (w_tick && !w_end));
    w_pcnt_nxt = (!w_phase || w_end) ? 6'd0 : r_pcnt + 6'(w_tick && !r_sclk);
    w_lat_nxt = r_state == IDLE ? w_accept : w_end ? r_state == SHIFT : r_lat;
    w_done_nxt = w_end && r_state == LAT_WR;
    w_busy_nxt = r_state == IDLE ? w_accept : w_done_nxt ? 1'b0 : r_busy;
  end

  assign bus.SCLK = r_sclk;
  assign bus.LAT = r_lat;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_led_band_fc_sequencer.sv
// tb_led_band_fc_sequencer: directed timing/count checks on two sequencer configurations
module tb_led_band_fc_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int n_vec = 0;
  int n_err = 0;
  int m_lat_up, m_lat_dn, m_rise1, m_r_en, m_r_sh, m_f_sh, m_r_wr, m_done;
  int m_hi_min, m_hi_max, m_lo_min, m_sep_min, m_busy1, m_done_busy;

  always #5 clk = ~clk;

  led_band_fc_sequencer_if bus_a ();
  led_band_fc_sequencer_if bus_b ();

  led_band_fc_sequencer u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  led_band_fc_sequencer #(.SCLK_HALF(5), .WRTFC_PULSES(5), .START_ON_RESET(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // times are counted in clks after the cycle in which the task is entered
  task automatic measure(input bit sel, input bit hold, input int budget);
    logic s, l, d, b, ps, pl;
    int ph, last_s, last_l;
    ps = 1'b0; pl = 1'b0; ph = 0; last_s = -1; last_l = -1;
    m_lat_up = -1; m_lat_dn = -1; m_rise1 = -1; m_done = -1; m_done_busy = -1; m_busy1 = -1;
    m_r_en = 0; m_r_sh = 0; m_f_sh = 0; m_r_wr = 0;
    m_hi_min = 1000000; m_hi_max = 0; m_lo_min = 1000000; m_sep_min = 1000000;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (n == 1 && !hold) begin
        if (sel) bus_b.start = 1'b0;
        else bus_a.start = 1'b0;
      end
      s = sel ? bus_b.SCLK : bus_a.SCLK;
      l = sel ? bus_b.LAT : bus_a.LAT;
      d = sel ? bus_b.done : bus_a.done;
      b = sel ? bus_b.busy : bus_a.busy;
      if (n == 1) m_busy1 = int'(b);
      if (l != pl) begin
        if (last_s >= 0 && n - last_s < m_sep_min) m_sep_min = n - last_s;
        last_l = n;
        ph++;
        if (ph == 1) m_lat_up = n;
        if (ph == 2) m_lat_dn = n;
      end
      if (s != ps) begin
        if (last_l >= 0 && n - last_l < m_sep_min) m_sep_min = n - last_l;
        if (last_s >= 0) begin
          if (s && n - last_s < m_lo_min) m_lo_min = n - last_s;
          if (!s && n - last_s < m_hi_min) m_hi_min = n - last_s;
          if (!s && n - last_s > m_hi_max) m_hi_max = n - last_s;
        end
        last_s = n;
        if (s) begin
          if (m_rise1 < 0) m_rise1 = n;
          if (ph == 1) m_r_en++;
          if (ph == 2) m_r_sh++;
          if (ph == 3) m_r_wr++;
        end else if (ph == 2) m_f_sh++;
      end
      ps = s;
      pl = l;
      if (d) begin
        m_done = n;
        m_done_busy = int'(b);
        break;
      end
    end
  endtask

  task automatic expect_seq(input string p, input int off, input int h);
    check({p, ".lat_up"}, m_lat_up, off + 1);
    check({p, ".sclk_rise1"}, m_rise1, off + 1 + h);
    check({p, ".lat_fall"}, m_lat_dn, off + 1 + 31 * h);
    check({p, ".done_at"}, m_done, off + 1 + 139 * h);
    check({p, ".fcwrten_rises"}, m_r_en, 15);
    check({p, ".shift_rises"}, m_r_sh, 48);
    check({p, ".shift_falls"}, m_f_sh, 48);
    check({p, ".wrtfc_rises"}, m_r_wr, 5);
    check({p, ".high_min"}, m_hi_min, h);
    check({p, ".high_max"}, m_hi_max, h);
    check({p, ".low_min"}, m_lo_min, h);
    check({p, ".lat_sclk_sep"}, m_sep_min, h);
    check({p, ".busy_at_done"}, m_done_busy, 0);
  endtask

  initial begin
    int edges;
    logic ps;
    rst_n = 1'b0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.sclk", int'(bus_a.SCLK), 0);
    check("rst.lat", int'(bus_a.LAT), 0);
    check("rst.busy", int'(bus_a.busy), 0);
    check("rst.done", int'(bus_a.done), 0);
    rst_n = 1'b1;
    measure(1'b0, 1'b0, 400);
    expect_seq("por", 0, 2);
    check("por.busy1", m_busy1, 1);
    @(negedge clk);
    check("por.done_width", int'(bus_a.done), 0);
    check("b.no_auto_start", int'(bus_b.busy), 0);
    bus_a.start = 1'b1;
    measure(1'b0, 1'b1, 400);
    expect_seq("hold1", 0, 2);
    measure(1'b0, 1'b1, 400);
    expect_seq("hold2", 1, 2);
    bus_a.start = 1'b0;
    edges = 0;
    ps = bus_a.SCLK;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_a.SCLK != ps) edges++;
      ps = bus_a.SCLK;
    end
    check("quiet.sclk_edges", edges, 0);
    check("quiet.busy", int'(bus_a.busy), 0);
    check("quiet.lat", int'(bus_a.LAT), 0);
    bus_b.start = 1'b1;
    measure(1'b1, 1'b0, 800);
    expect_seq("h5", 0, 5);
    check("h5.busy1", m_busy1, 1);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (100) @(negedge clk);
    check("mid.sclk_before", int'(bus_a.SCLK), 1);
    check("mid.lat_before", int'(bus_a.LAT), 0);
    check("mid.busy_before", int'(bus_a.busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid.sclk_after", int'(bus_a.SCLK), 0);
    check("mid.lat_after", int'(bus_a.LAT), 0);
    check("mid.busy_after", int'(bus_a.busy), 0);
    rst_n = 1'b1;
    measure(1'b0, 1'b0, 400);
    expect_seq("rerun", 0, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
